left_shifter_seq: RTL
=====================

# left_shifter_seq

Multi-cycle left shifter for the RISC5 execute stage, covering LSL (logical shift left, zero fill) and ROL (rotate left) on 32-bit operands. It complements the combinational ASR/ROR right shifter on the opposite shift direction. It trades barrel-shifter area for a fixed 3-cycle stall, using the same run/stall protocol as the multiplier and divider. Its result feeds the ALU result mux.

## Interface
Parameters: none.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  operation request; held high by the core until stall falls
- x  in  32  operand; sampled only in the launch cycle
- sc  in  5  shift count 0..31; sampled only in the launch cycle
- md  in  1  mode: 0 = LSL (zero fill), 1 = ROL (bits shifted out of [31] re-enter at [0]); sampled only in the launch cycle
- stall  out  1  high while the operation is in progress
- y  out  32  result register; valid in the cycle stall falls

## Operation
- 2-bit state counter S (IDLE=0, ST1=1, ST2=2, DONE=3). Registers: r[31:0], scr[4:2], mdr.
- Launch: S=0 and run=1.
  - r <= x shifted left by sc[1:0] (stage 1).
  - scr <= sc[4:2], mdr <= md.
  - S <= 1.
- S=0 and run=0: hold all state.
- S=1: r <= r shifted left by 4*scr[3:2] (0/4/8/12, stage 2); S <= 2.
- S=2: r <= r shifted left by 16*scr[4] (stage 3); S <= 3.
- S=3: r holds; S <= 0 unconditionally.
- Shift rule for every stage: vacated low bits are 0 when mdr=0 (md=0 in the launch cycle) and the outgoing high bits when rotating. Stage 1 uses md directly; stages 2 and 3 use mdr.
- y = r. It is a register output and never combinational from x.
- stall = run & (S != 3) & ~rst.
- A total shift count of sc mod 32 is exact for both modes. sc=0 returns x unchanged and still takes the full stall sequence.
- Changes to x, sc, or md after the launch cycle have no effect on the result.
- run dropping mid-operation (not a legal core behaviour): the sequence still completes and S returns to 0. stall reflects run combinationally.

## Timing
- Reset, synchronous on the clk edge with rst=1: S=0, r=0, scr=0, mdr=0. Outputs: y=0, stall=0. Reset overrides any in-flight operation and the result is discarded.
- Cycle-level sequence, with launch in cycle t:
  - cycles t, t+1, t+2: stall=1
  - cycle t+3: stall=0 and y holds the final result
  - cycle t+4: S=0
- Latency: 3 stall cycles. The result is valid in the 4th cycle after launch.
- Back-to-back operation: if run is still high at t+4, that cycle is a new launch using the x/sc/md present then.
- y keeps the last result until the next launch cycle's edge.

## Structure
- Shared package (the RISC5 ALU constants): opcode constants for LSL and ROL, shift-mode encodings MD_LSL=0 and MD_ROL=1, and state encodings S_IDLE/S_ST1/S_ST2/S_DONE.
- One sub-module is natural: shl_stage. It is a combinational function of data[31:0], amount (1/2/3 × unit), and rot, instantiated for the three radix stages (unit 1, 4, 16). The FSM and registers live in left_shifter_seq.

## Test plan
- LSL full range: x=0x0000_0001, sc=31, md=0, run held -> stall high exactly 3 cycles, then y=0x8000_0000 with stall=0.
- ROL carry-around: x=0x8000_0001, sc=1, md=1 -> y=0x0000_0003. Same operands with md=0 -> y=0x0000_0002.
- Multi-stage rotate: x=0x1234_5678, sc=20, md=1 -> y=0x6781_2345. With sc=4, md=1 -> y=0x2345_6781.
- Zero count and operand isolation: x=0xDEAD_BEEF, sc=0, md=0. Change x to 0 in the cycle after launch -> y=0xDEAD_BEEF, still 3 stall cycles.
- Back-to-back: keep run high across two ops (x=1, sc=8, md=0 then x=0xFF00_0000, sc=8, md=1):
  - first result: y=0x0000_0100
  - second result: y=0x0000_00FF, 4 cycles later
  - stall low for exactly one cycle between the two ops.
- Reset mid-operation: assert rst at launch+1 -> next cycle stall=0 and y=0. A new launch afterwards completes normally.

Source files
------------

// File: rtl/left_shifter_seq_pkg.sv
// Shared RISC5 ALU constants for the multi-cycle left shifter.
// Contents: ALU opcode constants (LSL/ROL), shift-mode encodings, FSM state
// encodings, operand widths and the launch request payload type.
package left_shifter_seq_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SC_W    = 5;
  localparam int unsigned STATE_W = 2;

  // ALU opcodes served by this unit
  localparam logic [3:0] OP_LSL = 4'd1;
  localparam logic [3:0] OP_ROL = 4'd15;

  // Shift mode encodings
  localparam logic MD_LSL = 1'b0;
  localparam logic MD_ROL = 1'b1;

  // FSM state encodings
  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_ST1  = 2'd1;
  localparam logic [STATE_W-1:0] S_ST2  = 2'd2;
  localparam logic [STATE_W-1:0] S_DONE = 2'd3;

  // Operand bundle sampled in the launch cycle
  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [SC_W-1:0]   sc;
    logic              md;
  } shl_req_t;

endpackage

// File: rtl/left_shifter_seq_if.sv
// Core-side run/stall bus of the left shifter.
// Signals: run (request), x (operand), sc (shift count), md (mode),
//          stall (busy), y (result register).
// Modports: master = execute stage, slave = shifter.
interface left_shifter_seq_if;
  import left_shifter_seq_pkg::*;

  logic              run;
  logic [DATA_W-1:0] x;
  logic [SC_W-1:0]   sc;
  logic              md;
  logic              stall;
  logic [DATA_W-1:0] y;

  modport master (
    output run, x, sc, md,
    input  stall, y
  );

  modport slave (
    input  run, x, sc, md,
    output stall, y
  );

endinterface

// File: rtl/left_shifter_seq_shl_stage.sv
// One radix stage of the left shifter: shifts data left by amount*UNIT bits,
// zero filling (rot=0) or rotating the outgoing bits back in (rot=1).
// Ports: data (in 32), amount (in 2, multiplier of UNIT), rot (in 1),
//        result_c (out 32, combinational).
// amount*UNIT must stay below 32 for the rotate path to be exact.
module shl_stage
  import left_shifter_seq_pkg::*;
#(
  parameter int unsigned UNIT = 1
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        amount,
  input  logic              rot,
  output logic [DATA_W-1:0] result_c
);

  localparam int unsigned SH_W = 6;

  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] shl;
  logic [DATA_W-1:0] wrap;

  assign shamt = SH_W'(amount) * SH_W'(UNIT);
  assign shl   = data << shamt;
  // For shamt=0 the right shift is by 32 and yields 0, so no special case
  assign wrap  = data >> (SH_W'(DATA_W) - shamt);

  assign result_c = rot ? (shl | wrap) : shl;

endmodule

// File: rtl/left_shifter_seq.sv
// Multi-cycle LSL/ROL unit for the execute stage. Splits a 0..31 left shift
// into three radix stages (1, 4, 16) across three stall cycles.
// Ports: clk, rst (sync, active-high), bus (slave: run/x/sc/md in,
//        stall/y out). y is the result register; stall is run-qualified.
module left_shifter_seq
  import left_shifter_seq_pkg::*;
(
  input logic              clk,
  input logic              rst,
  left_shifter_seq_if.slave bus
);

  logic [STATE_W-1:0] s_q, s_d;
  logic [DATA_W-1:0]  r_q, r_d;
  logic [4:2]         scr_q, scr_d;
  logic               mdr_q, mdr_d;

  shl_req_t           req;
  logic [DATA_W-1:0]  st1_c, st2_c, st3_c;

  assign req = '{x: bus.x, sc: bus.sc, md: bus.md};

  // Stage 1 works on the live operands, later stages on the captured ones
  shl_stage #(.UNIT(1)) u_st1 (
    .data     (req.x),
    .amount   (req.sc[1:0]),
    .rot      (req.md),
    .result_c (st1_c)
  );

  shl_stage #(.UNIT(4)) u_st2 (
    .data     (r_q),
    .amount   (scr_q[3:2]),
    .rot      (mdr_q),
    .result_c (st2_c)
  );

  shl_stage #(.UNIT(16)) u_st3 (
    .data     (r_q),
    .amount   ({1'b0, scr_q[4]}),
    .rot      (mdr_q),
    .result_c (st3_c)
  );

  // Next-state and datapath update
  always_comb begin
    s_d   = s_q;
    r_d   = r_q;
    scr_d = scr_q;
    mdr_d = mdr_q;
    case (s_q)
      S_IDLE: begin
        if (bus.run) begin
          r_d   = st1_c;
          scr_d = req.sc[4:2];
          mdr_d = req.md;
          s_d   = S_ST1;
        end
      end
      S_ST1: begin
        r_d = st2_c;
        s_d = S_ST2;
      end
      S_ST2: begin
        r_d = st3_c;
        s_d = S_DONE;
      end
      S_DONE: begin
        s_d = S_IDLE;
      end
      default: begin
        s_d = S_IDLE;
      end
    endcase
  end

  // State registers, synchronous reset discards any in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= S_IDLE;
      r_q   <= '0;
      scr_q <= '0;
      mdr_q <= MD_LSL;
    end else begin
      s_q   <= s_d;
      r_q   <= r_d;
      scr_q <= scr_d;
      mdr_q <= mdr_d;
    end
  end

  assign bus.y     = r_q;
  // Falls in the DONE cycle so the core can consume y and relaunch next cycle
  assign bus.stall = bus.run & (s_q != S_DONE) & ~rst;

endmodule
